// File: rtl/axi_arb_2x1.sv
// axi_arb_2x1: shares one AXI4 slave between two masters.
// Write (AW/B) and read (AR/R) paths are arbitrated independently with
// round-robin priority. Each path carries one transaction at a time and
// keeps its owner until the final response beat is accepted.
//
// Handshake rule: a transfer happens on a cycle where valid && ready are both
// high; valid never waits on ready, and the arbiter only routes ready from the
// slave back to the current owner (non-owners always see ready = 0).
module axi_arb_2x1 #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   // master 0 write
   input  logic                  m0_awvalid,
   input  logic [ADDR_WIDTH-1:0] m0_awaddr,
   input  logic [ID_WIDTH-1:0]   m0_awid,
   input  logic [7:0]            m0_awlen,
   output logic                  m0_awready,
   output logic                  m0_bvalid,
   output logic [ID_WIDTH-1:0]   m0_bid,
   output logic [1:0]            m0_bresp,
   input  logic                  m0_bready,
   // master 0 read
   input  logic                  m0_arvalid,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [ID_WIDTH-1:0]   m0_arid,
   input  logic [7:0]            m0_arlen,
   output logic                  m0_arready,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [ID_WIDTH-1:0]   m0_rid,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rlast,
   input  logic                  m0_rready,
   // master 1 write
   input  logic                  m1_awvalid,
   input  logic [ADDR_WIDTH-1:0] m1_awaddr,
   input  logic [ID_WIDTH-1:0]   m1_awid,
   input  logic [7:0]            m1_awlen,
   output logic                  m1_awready,
   output logic                  m1_bvalid,
   output logic [ID_WIDTH-1:0]   m1_bid,
   output logic [1:0]            m1_bresp,
   input  logic                  m1_bready,
   // master 1 read
   input  logic                  m1_arvalid,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [ID_WIDTH-1:0]   m1_arid,
   input  logic [7:0]            m1_arlen,
   output logic                  m1_arready,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ID_WIDTH-1:0]   m1_rid,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rlast,
   input  logic                  m1_rready,
   // slave write
   output logic                  s_awvalid,
   output logic [ADDR_WIDTH-1:0] s_awaddr,
   output logic [ID_WIDTH-1:0]   s_awid,
   output logic [7:0]            s_awlen,
   input  logic                  s_awready,
   input  logic                  s_bvalid,
   input  logic [ID_WIDTH-1:0]   s_bid,
   input  logic [1:0]            s_bresp,
   output logic                  s_bready,
   // slave read
   output logic                  s_arvalid,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [ID_WIDTH-1:0]   s_arid,
   output logic [7:0]            s_arlen,
   input  logic                  s_arready,
   input  logic                  s_rvalid,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [ID_WIDTH-1:0]   s_rid,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   output logic                  s_rready,
   // path state for observation (IDLE=0, ADDR=1, RESP=2)
   output logic [1:0]            dbg_wr_state,
   output logic [1:0]            dbg_rd_state
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_RESP = 2'd2} state_t;

   state_t wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic   wr_owner_q, wr_owner_d, wr_last_q, wr_last_d;
   logic   rd_owner_q, rd_owner_d, rd_last_q, rd_last_d;

   assign dbg_wr_state = wr_state_q;
   assign dbg_rd_state = rd_state_q;

   // State, owner and last-grant registers; last-grant resets to 1 so m0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q <= ST_IDLE;
         wr_owner_q <= 1'b0;
         wr_last_q  <= 1'b1;
         rd_state_q <= ST_IDLE;
         rd_owner_q <= 1'b0;
         rd_last_q  <= 1'b1;
      end else begin
         wr_state_q <= wr_state_d;
         wr_owner_q <= wr_owner_d;
         wr_last_q  <= wr_last_d;
         rd_state_q <= rd_state_d;
         rd_owner_q <= rd_owner_d;
         rd_last_q  <= rd_last_d;
      end
   end

   // Write path: grant, AW mux, and B routing by owner.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_owner_d = wr_owner_q;
      wr_last_d  = wr_last_q;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awid     = '0;
      s_awlen    = '0;
      s_bready   = 1'b0;
      m0_awready = 1'b0;
      m1_awready = 1'b0;
      m0_bvalid  = 1'b0;
      m0_bid     = '0;
      m0_bresp   = '0;
      m1_bvalid  = 1'b0;
      m1_bid     = '0;
      m1_bresp   = '0;
      case (wr_state_q)
         ST_IDLE: begin
            if (m0_awvalid || m1_awvalid) begin
               wr_owner_d = (m0_awvalid && m1_awvalid) ? ~wr_last_q : m1_awvalid;
               wr_state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (wr_owner_q) begin
               s_awvalid  = m1_awvalid;
               s_awaddr   = m1_awaddr;
               s_awid     = m1_awid;
               s_awlen    = m1_awlen;
               m1_awready = s_awready;
            end else begin
               s_awvalid  = m0_awvalid;
               s_awaddr   = m0_awaddr;
               s_awid     = m0_awid;
               s_awlen    = m0_awlen;
               m0_awready = s_awready;
            end
            if (s_awvalid && s_awready) wr_state_d = ST_RESP;
         end
         ST_RESP: begin
            if (wr_owner_q) begin
               m1_bvalid = s_bvalid;
               m1_bid    = s_bid;
               m1_bresp  = s_bresp;
               s_bready  = m1_bready;
            end else begin
               m0_bvalid = s_bvalid;
               m0_bid    = s_bid;
               m0_bresp  = s_bresp;
               s_bready  = m0_bready;
            end
            if (s_bvalid && s_bready) begin
               wr_state_d = ST_IDLE;
               wr_last_d  = wr_owner_q;
            end
         end
         default: wr_state_d = ST_IDLE;
      endcase
   end

   // Read path: grant, AR mux, and R routing by owner until the rlast beat.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_owner_d = rd_owner_q;
      rd_last_d  = rd_last_q;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rid     = '0;
      m0_rresp   = '0;
      m0_rlast   = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rid     = '0;
      m1_rresp   = '0;
      m1_rlast   = 1'b0;
      case (rd_state_q)
         ST_IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               rd_owner_d = (m0_arvalid && m1_arvalid) ? ~rd_last_q : m1_arvalid;
               rd_state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (rd_owner_q) begin
               s_arvalid  = m1_arvalid;
               s_araddr   = m1_araddr;
               s_arid     = m1_arid;
               s_arlen    = m1_arlen;
               m1_arready = s_arready;
            end else begin
               s_arvalid  = m0_arvalid;
               s_araddr   = m0_araddr;
               s_arid     = m0_arid;
               s_arlen    = m0_arlen;
               m0_arready = s_arready;
            end
            if (s_arvalid && s_arready) rd_state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rd_owner_q) begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
               m1_rid    = s_rid;
               m1_rresp  = s_rresp;
               m1_rlast  = s_rlast;
               s_rready  = m1_rready;
            end else begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
               m0_rid    = s_rid;
               m0_rresp  = s_rresp;
               m0_rlast  = s_rlast;
               s_rready  = m0_rready;
            end
            if (s_rvalid && s_rready && s_rlast) begin
               rd_state_d = ST_IDLE;
               rd_last_d  = rd_owner_q;
            end
         end
         default: rd_state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_arb_2x1.sv
// Directed bench for axi_arb_2x1; the bench plays both masters and the slave.
module tb_axi_arb_2x1;

  logic clk = 1'b0;
  logic reset;
  logic m0_awvalid, m0_awready, m0_bvalid, m0_bready, m0_arvalid, m0_arready;
  logic m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_awaddr, m0_araddr, m0_rdata;
  logic [3:0] m0_awid, m0_bid, m0_arid, m0_rid;
  logic [7:0] m0_awlen, m0_arlen;
  logic [1:0] m0_bresp, m0_rresp;
  logic m1_awvalid, m1_awready, m1_bvalid, m1_bready, m1_arvalid, m1_arready;
  logic m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_awaddr, m1_araddr, m1_rdata;
  logic [3:0] m1_awid, m1_bid, m1_arid, m1_rid;
  logic [7:0] m1_awlen, m1_arlen;
  logic [1:0] m1_bresp, m1_rresp;
  logic s_awvalid, s_awready, s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rvalid, s_rlast, s_rready;
  logic [31:0] s_awaddr, s_araddr, s_rdata;
  logic [3:0] s_awid, s_bid, s_arid, s_rid;
  logic [7:0] s_awlen, s_arlen;
  logic [1:0] s_bresp, s_rresp;
  logic [1:0] dbg_wr_state, dbg_rd_state;

  int total = 0;
  int bad = 0;

  axi_arb_2x1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
    .m0_awready(m0_awready), .m0_bvalid(m0_bvalid), .m0_bid(m0_bid), .m0_bresp(m0_bresp),
    .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rid(m0_rid),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awready(m1_awready), .m1_bvalid(m1_bvalid), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
    .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rid(m1_rid),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awready(s_awready), .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // OR of every DUT output: must be 0 whenever both paths are idle.
  logic any_out;
  assign any_out = |{m0_awready, m0_bvalid, m0_bid, m0_bresp, m0_arready, m0_rvalid,
                     m0_rdata, m0_rid, m0_rresp, m0_rlast,
                     m1_awready, m1_bvalid, m1_bid, m1_bresp, m1_arready, m1_rvalid,
                     m1_rdata, m1_rid, m1_rresp, m1_rlast,
                     s_awvalid, s_awaddr, s_awid, s_awlen, s_bready,
                     s_arvalid, s_araddr, s_arid, s_arlen, s_rready,
                     dbg_wr_state, dbg_rd_state};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_awvalid = 0; m0_awaddr = 0; m0_awid = 0; m0_awlen = 0; m0_bready = 0;
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_bready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_rready = 0;
    s_awready = 0; s_bvalid = 0; s_bid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rid = 0; s_rresp = 0; s_rlast = 0;
  endtask

  // One read of 4 beats while both masters hold arvalid; entered in the IDLE cycle.
  task automatic rd_tie_txn(input logic own);
    logic [31:0] exp_addr;
    exp_addr = own ? 32'h0000_00B0 : 32'h0000_00A0;
    cyc();
    chk("tie_s_arvalid", s_arvalid, 1);
    chk("tie_s_araddr", s_araddr, exp_addr);
    s_arready = 1;
    settle();
    chk("tie_owner_arready", own ? m1_arready : m0_arready, 1);
    chk("tie_other_arready", own ? m0_arready : m1_arready, 0);
    cyc();
    s_arready = 0;
    m0_rready = 1;
    m1_rready = 1;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1;
      s_rdata = 32'hD000_0000 + (own ? 32'h10 : 32'h0) + b;
      s_rid = own ? 4'd2 : 4'd1;
      s_rlast = (b == 3);
      settle();
      chk("tie_owner_rvalid", own ? m1_rvalid : m0_rvalid, 1);
      chk("tie_owner_rdata", own ? m1_rdata : m0_rdata,
          32'hD000_0000 + (own ? 32'h10 : 32'h0) + b);
      chk("tie_owner_rlast", own ? m1_rlast : m0_rlast, (b == 3) ? 1 : 0);
      chk("tie_other_rvalid", own ? m0_rvalid : m1_rvalid, 0);
      cyc();
    end
    s_rvalid = 0;
    s_rlast = 0;
    settle();
    chk("tie_back_idle", dbg_rd_state, 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    settle();
    chk("reset_all_zero", any_out, 0);

    // ---- single write from m0 ----
    m0_awvalid = 1; m0_awaddr = 32'h100; m0_awid = 4'd3;
    settle();
    chk("wr_no_valid_in_idle", s_awvalid, 0);
    cyc();
    chk("wr_s_awvalid_t1", s_awvalid, 1);
    chk("wr_s_awaddr", s_awaddr, 32'h100);
    chk("wr_s_awid", s_awid, 3);
    s_awready = 1;
    settle();
    chk("wr_m0_awready", m0_awready, 1);
    chk("wr_m1_awready", m1_awready, 0);
    cyc();
    m0_awvalid = 0; s_awready = 0;
    s_bvalid = 1; s_bid = 4'd3; s_bresp = 2'd0; m0_bready = 1;
    settle();
    chk("wr_s_awvalid_resp", s_awvalid, 0);
    chk("wr_m0_bvalid", m0_bvalid, 1);
    chk("wr_m0_bid", m0_bid, 3);
    chk("wr_m0_bresp", m0_bresp, 0);
    chk("wr_m1_bvalid", m1_bvalid, 0);
    chk("wr_s_bready", s_bready, 1);
    cyc();
    s_bvalid = 0; s_bid = 0; m0_bready = 0;
    settle();
    chk("wr_idle_after_b", dbg_wr_state, 0);
    chk("wr_m0_bvalid_drop", m0_bvalid, 0);

    // ---- tie and fairness on read path ----
    m0_arvalid = 1; m0_araddr = 32'hA0; m0_arid = 4'd1; m0_arlen = 8'd3;
    m1_arvalid = 1; m1_araddr = 32'hB0; m1_arid = 4'd2; m1_arlen = 8'd3;
    rd_tie_txn(1'b0);
    rd_tie_txn(1'b1);
    rd_tie_txn(1'b0);
    rd_tie_txn(1'b1);
    clear_inputs();
    cyc();

    // ---- concurrent write (m0) and read (m1) ----
    m0_awvalid = 1; m0_awaddr = 32'h200; m0_awid = 4'd5;
    m1_arvalid = 1; m1_araddr = 32'h300; m1_arid = 4'd5; m1_arlen = 8'd0;
    cyc();
    chk("cc_s_awvalid", s_awvalid, 1);
    chk("cc_s_arvalid", s_arvalid, 1);
    chk("cc_s_awaddr", s_awaddr, 32'h200);
    chk("cc_s_araddr", s_araddr, 32'h300);
    s_awready = 1; s_arready = 1;
    settle();
    chk("cc_m0_awready", m0_awready, 1);
    chk("cc_m1_arready", m1_arready, 1);
    chk("cc_m1_awready", m1_awready, 0);
    chk("cc_m0_arready", m0_arready, 0);
    cyc();
    clear_inputs();
    s_bvalid = 1; s_bid = 4'd5; s_bresp = 2'd2; m0_bready = 1;
    s_rvalid = 1; s_rdata = 32'hCAFE_0001; s_rid = 4'd5; s_rlast = 1; m1_rready = 1;
    settle();
    chk("cc_m0_bvalid", m0_bvalid, 1);
    chk("cc_m0_bresp", m0_bresp, 2);
    chk("cc_m1_bvalid", m1_bvalid, 0);
    chk("cc_m1_rvalid", m1_rvalid, 1);
    chk("cc_m1_rdata", m1_rdata, 32'hCAFE_0001);
    chk("cc_m0_rvalid", m0_rvalid, 0);
    cyc();
    clear_inputs();
    settle();
    chk("cc_both_idle", any_out, 0);

    // ---- backpressure on m0 read ----
    m0_arvalid = 1; m0_araddr = 32'h400; m0_arid = 4'd7; m0_arlen = 8'd3;
    cyc();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_s_arvalid_held", s_arvalid, 1);
      chk("bp_m0_arready_low", m0_arready, 0);
      cyc();
    end
    s_arready = 1;
    settle();
    chk("bp_m0_arready_high", m0_arready, 1);
    cyc();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1111_0000; s_rid = 4'd7; s_rlast = 0; m0_rready = 1;
    settle();
    chk("bp_beat0", m0_rdata, 32'h1111_0000);
    chk("bp_s_rready_hi", s_rready, 1);
    cyc();
    s_rdata = 32'h1111_0001; m0_rready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_s_rready_lo", s_rready, 0);
      chk("bp_beat1_held", m0_rdata, 32'h1111_0001);
      cyc();
    end
    m0_rready = 1;
    settle();
    chk("bp_s_rready_back", s_rready, 1);
    cyc();
    s_rdata = 32'h1111_0002;
    settle();
    chk("bp_beat2", m0_rdata, 32'h1111_0002);
    cyc();
    s_rdata = 32'h1111_0003; s_rlast = 1;
    settle();
    chk("bp_still_resp", dbg_rd_state, 2);
    chk("bp_beat3_last", m0_rlast, 1);
    cyc();
    clear_inputs();
    settle();
    chk("bp_idle", dbg_rd_state, 0);

    // ---- reset mid-read (m1 owns; last-grant is m0, so only reset makes m0 win a tie) ----
    m1_arvalid = 1; m1_araddr = 32'h500; m1_arid = 4'd9; m1_arlen = 8'd3;
    cyc();
    s_arready = 1;
    cyc();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rid = 4'd9; m1_rready = 1;
    s_rdata = 32'h2222_0000;
    cyc();
    s_rdata = 32'h2222_0001;
    settle();
    chk("rst_beat2_to_m1", m1_rdata, 32'h2222_0001);
    cyc();
    s_rdata = 32'h2222_0002;
    reset = 1;
    cyc();
    reset = 0;
    clear_inputs();
    settle();
    chk("rst_all_zero", any_out, 0);
    m0_arvalid = 1; m0_araddr = 32'h600; m0_arid = 4'd1;
    m1_arvalid = 1; m1_araddr = 32'h700; m1_arid = 4'd2;
    cyc();
    chk("rst_tie_addr_m0", s_araddr, 32'h600);
    s_arready = 1;
    settle();
    chk("rst_tie_m0_arready", m0_arready, 1);
    chk("rst_tie_m1_arready", m1_arready, 0);
    cyc();
    clear_inputs();
    s_rvalid = 1; s_rlast = 1; m0_rready = 1;
    cyc();
    clear_inputs();
    settle();
    chk("rst_tie_done", dbg_rd_state, 0);

    // ---- back-to-back writes: m0 then pending m1 ----
    m0_awvalid = 1; m0_awaddr = 32'h800; m0_awid = 4'd4;
    cyc();
    m1_awvalid = 1; m1_awaddr = 32'h900; m1_awid = 4'd6;
    s_awready = 1;
    settle();
    chk("b2b_m0_awready", m0_awready, 1);
    chk("b2b_m1_wait", m1_awready, 0);
    cyc();
    m0_awvalid = 0; s_awready = 0;
    s_bvalid = 1; s_bid = 4'd4; m0_bready = 1;
    settle();
    chk("b2b_m1_wait_resp", m1_awready, 0);
    chk("b2b_m0_bvalid", m0_bvalid, 1);
    cyc();
    s_bvalid = 0; m0_bready = 0;
    settle();
    chk("b2b_t1_idle", dbg_wr_state, 0);
    chk("b2b_t1_no_valid", s_awvalid, 0);
    cyc();
    chk("b2b_t2_valid", s_awvalid, 1);
    chk("b2b_t2_addr", s_awaddr, 32'h900);
    chk("b2b_t2_id", s_awid, 6);
    s_awready = 1;
    cyc();
    m1_awvalid = 0; s_awready = 0;
    s_bvalid = 1; s_bid = 4'd6; s_bresp = 2'd1; m1_bready = 1;
    settle();
    chk("b2b_m1_bvalid", m1_bvalid, 1);
    chk("b2b_m1_bresp", m1_bresp, 1);
    chk("b2b_m0_bvalid_off", m0_bvalid, 0);
    cyc();
    clear_inputs();
    settle();
    chk("end_all_zero", any_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
